fifo_wr_sched: RTL and testbench

- Round-robin scheduler that shares one 128-to-64 FIFO write converter between NREQ 128-bit producers (e.g. encrypt and sort engines).
- Grants one requester at a time for a whole burst of LEN words.
- Optionally prepends a 128-bit header word per burst.
- Drives the converter's rdy / i_push / idata handshake, so only one burst is in flight at the converter.

---
 rtl/fifo_wr_sched.sv | 163 ++++++++++++++++
 tb/tb_fifo_wr_sched.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_sched.sv
// Round-robin scheduler sharing one 128-bit FIFO write converter between NREQ producers.
// Each grant covers a whole burst (optional header word + LEN data words).
module fifo_wr_sched #(
    parameter int NREQ   = 2,
    parameter int LEN_W  = 8,
    parameter int HDR_EN = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       s_req,
    input  logic [NREQ*LEN_W-1:0] s_len,
    input  logic [NREQ-1:0]       s_valid,
    input  logic [NREQ*128-1:0]   s_data,
    output logic [NREQ-1:0]       s_ack,
    output logic [NREQ-1:0]       s_done,
    input  logic                  dn_rdy,
    output logic                  dn_push,
    output logic [127:0]          dn_data,
    output logic                  busy,
    output logic [1:0]            cur_src
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HDR  = 2'd1;
    localparam logic [1:0] DATA = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [1:0]       rr_ptr_q, rr_ptr_d;
    logic [1:0]       grant_q, grant_d;
    logic [LEN_W-1:0] words_left_q, words_left_d;

    // Requester buses padded to four slots so a 2-bit grant always indexes in range.
    logic [3:0]       req_pad;
    logic [3:0]       valid_pad;
    logic [LEN_W-1:0] len_arr  [4];
    logic [127:0]     data_arr [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_pad
            if (gi < NREQ) begin : g_used
                assign req_pad[gi]   = s_req[gi];
                assign valid_pad[gi] = s_valid[gi];
                assign len_arr[gi]   = s_len[gi*LEN_W +: LEN_W];
                assign data_arr[gi]  = s_data[gi*128 +: 128];
            end else begin : g_unused
                assign req_pad[gi]   = 1'b0;
                assign valid_pad[gi] = 1'b0;
                assign len_arr[gi]   = '0;
                assign data_arr[gi]  = '0;
            end
        end
    endgenerate

    // First requester at or after rr_ptr, wrapping modulo NREQ.
    logic [1:0] sel;
    logic       req_any;
    logic [2:0] cand;
    always_comb begin
        sel     = 2'd0;
        req_any = 1'b0;
        cand    = 3'd0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr_ptr_q} + 3'(k);
            if (cand >= 3'(NREQ)) begin
                cand = cand - 3'(NREQ);
            end
            if (!req_any && req_pad[cand[1:0]]) begin
                req_any = 1'b1;
                sel     = cand[1:0];
            end
        end
    end

    // Push must stay combinational: the converter drops rdy on the edge after acceptance.
    logic        data_push;
    logic [15:0] hdr_len;
    always_comb begin
        dn_push              = 1'b0;
        dn_data              = '0;
        data_push            = 1'b0;
        hdr_len              = '0;
        hdr_len[LEN_W-1:0]   = words_left_q;
        case (state_q)
            HDR: begin
                dn_push = dn_rdy;
                dn_data = {8'hA5, 6'd0, grant_q, hdr_len, 96'd0};
            end
            DATA: begin
                data_push = dn_rdy & valid_pad[grant_q];
                dn_push   = data_push;
                dn_data   = data_arr[grant_q];
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_d      = grant_q;
        words_left_d = words_left_q;
        case (state_q)
            IDLE: begin
                if (req_any) begin
                    grant_d      = sel;
                    words_left_d = len_arr[sel];
                    if (HDR_EN != 0) begin
                        state_d = HDR;
                    end else if (len_arr[sel] != '0) begin
                        state_d = DATA;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            HDR: begin
                if (dn_rdy) begin
                    state_d = (words_left_q != '0) ? DATA : DONE;
                end
            end
            DATA: begin
                // words_left is nonzero on entry to DATA, so this never underflows.
                if (data_push) begin
                    words_left_d = words_left_q - 1'b1;
                    if (words_left_q == LEN_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            default: begin
                rr_ptr_d = (grant_q == 2'(NREQ - 1)) ? 2'd0 : grant_q + 2'd1;
                state_d  = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            rr_ptr_q     <= 2'd0;
            grant_q      <= 2'd0;
            words_left_q <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_q      <= grant_d;
            words_left_q <= words_left_d;
        end
    end

    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_hs
            assign s_ack[gi]  = data_push && (grant_q == 2'(gi));
            assign s_done[gi] = (state_q == DONE) && (grant_q == 2'(gi));
        end
    endgenerate

    assign busy    = (state_q != IDLE);
    assign cur_src = busy ? grant_q : 2'd0;

endmodule

// File: tb/tb_fifo_wr_sched.sv
// Directed bench for fifo_wr_sched: three instances cover header/no-header and 2/4 requesters.
module tb_fifo_wr_sched;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Instance A: NREQ=2, HDR_EN=1
    logic [1:0]   a_s_req, a_s_valid, a_s_ack, a_s_done;
    logic [15:0]  a_s_len;
    logic [255:0] a_s_data;
    logic         a_dn_rdy, a_dn_push, a_busy;
    logic [127:0] a_dn_data;
    logic [1:0]   a_cur_src;

    // Instance B: NREQ=2, HDR_EN=0
    logic [1:0]   b_s_req, b_s_valid, b_s_ack, b_s_done;
    logic [15:0]  b_s_len;
    logic [255:0] b_s_data;
    logic         b_dn_rdy, b_dn_push, b_busy;
    logic [127:0] b_dn_data;
    logic [1:0]   b_cur_src;

    // Instance C: NREQ=4, HDR_EN=1
    logic [3:0]   c_s_req, c_s_valid, c_s_ack, c_s_done;
    logic [31:0]  c_s_len;
    logic [511:0] c_s_data;
    logic         c_dn_rdy, c_dn_push, c_busy;
    logic [127:0] c_dn_data;
    logic [1:0]   c_cur_src;

    fifo_wr_sched #(.NREQ(2), .LEN_W(8), .HDR_EN(1)) u_a (
        .clk(clk), .reset(reset), .s_req(a_s_req), .s_len(a_s_len), .s_valid(a_s_valid),
        .s_data(a_s_data), .s_ack(a_s_ack), .s_done(a_s_done), .dn_rdy(a_dn_rdy),
        .dn_push(a_dn_push), .dn_data(a_dn_data), .busy(a_busy), .cur_src(a_cur_src));

    fifo_wr_sched #(.NREQ(2), .LEN_W(8), .HDR_EN(0)) u_b (
        .clk(clk), .reset(reset), .s_req(b_s_req), .s_len(b_s_len), .s_valid(b_s_valid),
        .s_data(b_s_data), .s_ack(b_s_ack), .s_done(b_s_done), .dn_rdy(b_dn_rdy),
        .dn_push(b_dn_push), .dn_data(b_dn_data), .busy(b_busy), .cur_src(b_cur_src));

    fifo_wr_sched #(.NREQ(4), .LEN_W(8), .HDR_EN(1)) u_c (
        .clk(clk), .reset(reset), .s_req(c_s_req), .s_len(c_s_len), .s_valid(c_s_valid),
        .s_data(c_s_data), .s_ack(c_s_ack), .s_done(c_s_done), .dn_rdy(c_dn_rdy),
        .dn_push(c_dn_push), .dn_data(c_dn_data), .busy(c_busy), .cur_src(c_cur_src));

    function automatic logic [127:0] word(input int r, input int n);
        return {8'hD0, r[7:0], 80'h0, n[31:0]};
    endfunction

    function automatic logic [127:0] hdr(input int g, input int len);
        return {8'hA5, g[7:0], len[15:0], 96'h0};
    endfunction

    // Producer model for A: each requester steps to its next word on every ack.
    int idx_a0 = 0;
    int idx_a1 = 0;
    always @(posedge clk) begin
        if (a_s_ack[0]) idx_a0 <= idx_a0 + 1;
        if (a_s_ack[1]) idx_a1 <= idx_a1 + 1;
    end
    assign a_s_data = {word(1, idx_a1), word(0, idx_a0)};

    // Monitors sample on the falling edge, away from the active edge.
    logic [127:0] push_a[$];
    logic [1:0]   done_a[$];
    int           ack_a0 = 0, ack_a1 = 0, ackbad_a = 0, push_b = 0;
    logic [1:0]   done_b[$];
    logic [3:0]   done_c[$];
    logic [1:0]   cur_c[$];
    always @(negedge clk) begin
        if (!reset) begin
            if (a_dn_push) push_a.push_back(a_dn_data);
            if (a_s_done != 2'b00) done_a.push_back(a_s_done);
            if (a_s_ack[0]) ack_a0++;
            if (a_s_ack[1]) ack_a1++;
            if (a_s_ack != 2'b00 && !a_dn_push) ackbad_a++;
            if (b_dn_push) push_b++;
            if (b_s_done != 2'b00) done_b.push_back(b_s_done);
            if (c_s_done != 4'b0000) done_c.push_back(c_s_done);
            if (c_dn_push && c_dn_data[127:120] == 8'hA5) cur_c.push_back(c_cur_src);
        end
    end

    // Drives A until ndone bursts finish, dropping each requester's s_req after its s_done.
    task automatic run_a(input int ndone, input int period, input int bound, output bit tmo);
        int cyc;
        int d0;
        cyc = 0;
        tmo = 1'b0;
        d0  = done_a.size();
        while (done_a.size() - d0 < ndone) begin
            @(posedge clk); #1;
            for (int k = d0; k < done_a.size(); k++) a_s_req = a_s_req & ~done_a[k];
            a_dn_rdy = (period <= 1) ? 1'b1 : ((cyc % period) == period - 1);
            cyc++;
            if (cyc > bound) begin
                tmo = 1'b1;
                break;
            end
        end
        a_dn_rdy = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        a_s_req = 2'b11; a_s_valid = 2'b11; a_dn_rdy = 1'b1; a_s_len = {8'd2, 8'd2};
        repeat (2) @(posedge clk);
        #1;
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", a_busy); end
        checks++; if (a_cur_src !== 2'd0) begin errors++; $display("FAIL reset_cur_src: got %0d want 0", a_cur_src); end
        checks++; if (a_dn_push !== 1'b0) begin errors++; $display("FAIL reset_dn_push: got %0b want 0", a_dn_push); end
        checks++; if (a_dn_data !== 128'd0) begin errors++; $display("FAIL reset_dn_data: got %h want 0", a_dn_data); end
        checks++; if (a_s_ack !== 2'b00) begin errors++; $display("FAIL reset_s_ack: got %b want 00", a_s_ack); end
        checks++; if (a_s_done !== 2'b00) begin errors++; $display("FAIL reset_s_done: got %b want 00", a_s_done); end
        a_s_req = 2'b00; a_s_valid = 2'b00; a_dn_rdy = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        $display("reset: outputs idle");
    endtask

    task automatic test_hdr_burst();
        int p0, a0, d0, base;
        bit tmo;
        p0 = push_a.size(); a0 = ack_a0; d0 = done_a.size(); base = idx_a0;
        a_s_len[7:0] = 8'd3; a_s_valid = 2'b01; a_s_req = 2'b01;
        run_a(1, 3, 200, tmo);
        a_s_valid = 2'b00;
        checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL hdr_timeout: got %0b want 0", tmo); end
        checks++; if (push_a.size() - p0 !== 4) begin errors++; $display("FAIL hdr_push_count: got %0d want 4", push_a.size() - p0); end
        checks++; if (push_a[p0] !== 128'hA5000003_00000000_00000000_00000000) begin
            errors++; $display("FAIL hdr_word: got %h want a5000003000000000000000000000000", push_a[p0]); end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (push_a[p0+1+k] !== word(0, base + k)) begin
                errors++; $display("FAIL hdr_data%0d: got %h want %h", k, push_a[p0+1+k], word(0, base + k)); end
        end
        checks++; if (ack_a0 - a0 !== 3) begin errors++; $display("FAIL hdr_acks: got %0d want 3", ack_a0 - a0); end
        checks++; if (done_a.size() - d0 !== 1) begin errors++; $display("FAIL hdr_done_count: got %0d want 1", done_a.size() - d0); end
        checks++; if (done_a[d0] !== 2'b01) begin errors++; $display("FAIL hdr_done_bit: got %b want 01", done_a[d0]); end
        $display("hdr_burst: pushes=%0d acks=%0d", push_a.size() - p0, ack_a0 - a0);
    endtask

    task automatic test_back_to_back();
        int p0, d0, b0, b1;
        bit tmo;
        logic [127:0] exp[6];
        pulse_reset();
        for (int pass = 0; pass < 2; pass++) begin
            p0 = push_a.size(); d0 = done_a.size(); b0 = idx_a0; b1 = idx_a1;
            a_s_len = {8'd2, 8'd2}; a_s_valid = 2'b11; a_s_req = 2'b11;
            run_a(2, 1, 200, tmo);
            a_s_valid = 2'b00;
            exp[0] = hdr(0, 2); exp[1] = word(0, b0); exp[2] = word(0, b0 + 1);
            exp[3] = hdr(1, 2); exp[4] = word(1, b1); exp[5] = word(1, b1 + 1);
            checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL b2b%0d_timeout: got %0b want 0", pass, tmo); end
            checks++; if (done_a[d0] !== 2'b01) begin errors++; $display("FAIL b2b%0d_first_done: got %b want 01", pass, done_a[d0]); end
            checks++; if (done_a[d0+1] !== 2'b10) begin errors++; $display("FAIL b2b%0d_second_done: got %b want 10", pass, done_a[d0+1]); end
            checks++; if (push_a.size() - p0 !== 6) begin errors++; $display("FAIL b2b%0d_push_count: got %0d want 6", pass, push_a.size() - p0); end
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (push_a[p0+k] !== exp[k]) begin
                    errors++; $display("FAIL b2b%0d_word%0d: got %h want %h", pass, k, push_a[p0+k], exp[k]); end
            end
            $display("back_to_back pass %0d: done order %b,%b", pass, done_a[d0], done_a[d0+1]);
        end
    endtask

    task automatic test_stall();
        int p0, base, np, na, cyc;
        bit tmo;
        p0 = push_a.size(); base = idx_a0;
        a_s_len[7:0] = 8'd4; a_s_valid = 2'b01; a_s_req = 2'b01; a_dn_rdy = 1'b1;
        cyc = 0;
        while (push_a.size() - p0 < 2 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        a_dn_rdy = 1'b0;
        np = push_a.size(); na = ack_a0;
        repeat (10) @(posedge clk);
        #1;
        checks++; if (push_a.size() !== np) begin errors++; $display("FAIL stall_rdy_push: got %0d want %0d", push_a.size(), np); end
        checks++; if (ack_a0 !== na) begin errors++; $display("FAIL stall_rdy_ack: got %0d want %0d", ack_a0, na); end
        checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL stall_busy: got %0b want 1", a_busy); end
        a_dn_rdy = 1'b1; a_s_valid = 2'b00;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (push_a.size() !== np) begin errors++; $display("FAIL stall_valid_push: got %0d want %0d", push_a.size(), np); end
        checks++; if (ack_a0 !== na) begin errors++; $display("FAIL stall_valid_ack: got %0d want %0d", ack_a0, na); end
        a_s_valid = 2'b01;
        run_a(1, 1, 100, tmo);
        a_s_valid = 2'b00;
        checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL stall_timeout: got %0b want 0", tmo); end
        checks++; if (push_a.size() - p0 !== 5) begin errors++; $display("FAIL stall_push_count: got %0d want 5", push_a.size() - p0); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (push_a[p0+1+k] !== word(0, base + k)) begin
                errors++; $display("FAIL stall_data%0d: got %h want %h", k, push_a[p0+1+k], word(0, base + k)); end
        end
        checks++; if (ackbad_a !== 0) begin errors++; $display("FAIL ack_without_push: got %0d want 0", ackbad_a); end
        $display("stall: pushes=%0d", push_a.size() - p0);
    endtask

    task automatic test_len_zero();
        int p0, d0, a1, pb0, db0;
        bit tmo;
        p0 = push_a.size(); d0 = done_a.size(); a1 = ack_a1;
        a_s_len[15:8] = 8'd0; a_s_valid = 2'b10; a_s_req = 2'b10;
        run_a(1, 1, 50, tmo);
        a_s_valid = 2'b00;
        checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL len0_timeout: got %0b want 0", tmo); end
        checks++; if (push_a.size() - p0 !== 1) begin errors++; $display("FAIL len0_push_count: got %0d want 1", push_a.size() - p0); end
        checks++; if (push_a[p0] !== 128'hA5010000_00000000_00000000_00000000) begin
            errors++; $display("FAIL len0_hdr: got %h want a5010000000000000000000000000000", push_a[p0]); end
        checks++; if (done_a[d0] !== 2'b10) begin errors++; $display("FAIL len0_done: got %b want 10", done_a[d0]); end
        checks++; if (ack_a1 !== a1) begin errors++; $display("FAIL len0_ack: got %0d want %0d", ack_a1, a1); end
        // Header-less instance: IDLE grants straight into DONE.
        pb0 = push_b; db0 = done_b.size();
        @(posedge clk); #1;
        b_s_len = 16'd0; b_dn_rdy = 1'b1; b_s_req = 2'b01;
        checks++; if (b_s_done !== 2'b00) begin errors++; $display("FAIL nohdr_done_early: got %b want 00", b_s_done); end
        @(posedge clk); #1;
        checks++; if (b_s_done !== 2'b01) begin errors++; $display("FAIL nohdr_done: got %b want 01", b_s_done); end
        checks++; if (b_cur_src !== 2'd0) begin errors++; $display("FAIL nohdr_cur_src: got %0d want 0", b_cur_src); end
        b_s_req = 2'b00;
        @(posedge clk); #1;
        checks++; if (b_s_done !== 2'b00) begin errors++; $display("FAIL nohdr_done_pulse: got %b want 00", b_s_done); end
        checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL nohdr_busy: got %0b want 0", b_busy); end
        repeat (2) @(posedge clk);
        #1;
        b_dn_rdy = 1'b0;
        checks++; if (push_b - pb0 !== 0) begin errors++; $display("FAIL nohdr_push: got %0d want 0", push_b - pb0); end
        checks++; if (done_b.size() - db0 !== 1) begin errors++; $display("FAIL nohdr_done_count: got %0d want 1", done_b.size() - db0); end
        $display("len_zero: hdr-only pushes=%0d, no-hdr pushes=%0d", push_a.size() - p0, push_b - pb0);
    endtask

    task automatic test_reset_abort();
        int p0, d0, cyc;
        bit tmo;
        a_s_len = {8'd1, 8'd1}; a_s_valid = 2'b01; a_s_req = 2'b01;
        run_a(1, 1, 50, tmo);
        p0 = push_a.size();
        a_s_len[7:0] = 8'd4; a_s_req = 2'b01; a_dn_rdy = 1'b1;
        cyc = 0;
        while (push_a.size() - p0 < 2 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        #1;
        reset = 1'b1;
        d0 = done_a.size();
        #1;
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %0b want 0", a_busy); end
        checks++; if (a_dn_push !== 1'b0) begin errors++; $display("FAIL abort_push: got %0b want 0", a_dn_push); end
        a_s_req = 2'b00; a_dn_rdy = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (done_a.size() !== d0) begin errors++; $display("FAIL abort_no_done: got %0d want %0d", done_a.size(), d0); end
        checks++; if (a_s_done !== 2'b00) begin errors++; $display("FAIL abort_s_done: got %b want 00", a_s_done); end
        // Before the abort rr_ptr pointed at requester 1; reset must return it to 0.
        a_s_len = {8'd1, 8'd1}; a_s_valid = 2'b11; a_s_req = 2'b11;
        run_a(2, 1, 100, tmo);
        a_s_valid = 2'b00;
        checks++; if (tmo !== 1'b0) begin errors++; $display("FAIL abort_rr_timeout: got %0b want 0", tmo); end
        checks++; if (done_a[d0] !== 2'b01) begin errors++; $display("FAIL abort_rr_first: got %b want 01", done_a[d0]); end
        $display("reset_abort: first grant after reset done=%b", done_a[d0]);
    endtask

    task automatic test_four_way();
        int d0, k0, cyc;
        logic [3:0] exp_done[5];
        logic [1:0] exp_src[5];
        exp_done[0] = 4'b0001; exp_done[1] = 4'b0010; exp_done[2] = 4'b0100;
        exp_done[3] = 4'b1000; exp_done[4] = 4'b0001;
        exp_src[0] = 2'd0; exp_src[1] = 2'd1; exp_src[2] = 2'd2; exp_src[3] = 2'd3; exp_src[4] = 2'd0;
        d0 = done_c.size(); k0 = cur_c.size();
        c_s_len = {8'd1, 8'd1, 8'd1, 8'd1}; c_s_valid = 4'hF; c_dn_rdy = 1'b1; c_s_req = 4'hF;
        cyc = 0;
        while (done_c.size() - d0 < 5 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        c_s_req = 4'h0; c_s_valid = 4'h0; c_dn_rdy = 1'b0;
        checks++; if (done_c.size() - d0 !== 5) begin errors++; $display("FAIL rr4_done_count: got %0d want 5", done_c.size() - d0); end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (done_c[d0+k] !== exp_done[k]) begin
                errors++; $display("FAIL rr4_done%0d: got %b want %b", k, done_c[d0+k], exp_done[k]); end
            checks++;
            if (cur_c[k0+k] !== exp_src[k]) begin
                errors++; $display("FAIL rr4_cur_src%0d: got %0d want %0d", k, cur_c[k0+k], exp_src[k]); end
        end
        $display("four_way: %0d bursts in %0d cycles", done_c.size() - d0, cyc);
    endtask

    initial begin
        reset = 1'b1;
        a_s_req = '0; a_s_valid = '0; a_s_len = '0; a_dn_rdy = 1'b0;
        b_s_req = '0; b_s_valid = '0; b_s_len = '0; b_s_data = '0; b_dn_rdy = 1'b0;
        c_s_req = '0; c_s_valid = '0; c_s_len = '0; c_s_data = '0; c_dn_rdy = 1'b0;
        test_reset();
        test_hdr_burst();
        test_back_to_back();
        test_stall();
        test_len_zero();
        test_reset_abort();
        test_four_way();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
